n64_eeprom_port_arbiter: RTL

- Shares the 32-bit host port of the N64 EEPROM block RAM (inside the SI controller) between two requesters: requester 0 is the CPU/USB bus bridge, requester 1 is the save-writeback engine.
- Round-robin grant with one outstanding transaction at a time.
- Registered downstream outputs.
- Single-cycle write issue; read completion is taken from the SI port ack.

---
 rtl/n64_eeprom_pkg.sv | 15 +
 rtl/n64_eeprom_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/n64_eeprom_pkg.sv
// Shared types and constants for the N64 EEPROM host-port arbiter.
package n64_eeprom_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITE_ACK = 2'd1,
        S_READ_WAIT = 2'd2
    } state_t;

    localparam logic REQ_CPU  = 1'b0;
    localparam logic REQ_SAVE = 1'b1;

    localparam logic [31:0] TIMEOUT_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/n64_eeprom_port_arbiter.sv
// Round-robin arbiter sharing the SI EEPROM block-RAM host port between the CPU bridge and the save engine.
// Optional read-ack watchdog enabled by defining N64_EEPROM_ARB_TIMEOUT_EN.
module n64_eeprom_port_arbiter
    import n64_eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
`ifdef N64_EEPROM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 15
`endif
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_request_0,
    input  logic              i_write_0,
    input  logic [ADDR_W-1:0] i_address_0,
    input  logic [DATA_W-1:0] i_data_0,
    output logic              o_ack_0,
    output logic [DATA_W-1:0] o_data_0,
    input  logic              i_request_1,
    input  logic              i_write_1,
    input  logic [ADDR_W-1:0] i_address_1,
    input  logic [DATA_W-1:0] i_data_1,
    output logic              o_ack_1,
    output logic [DATA_W-1:0] o_data_1,
    output logic              o_request,
    output logic              o_write,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_busy,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_error
);

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                wr_ack;
    logic                sel_valid;
    logic                sel_id;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W-1:0]   sel_data;
    logic                issue;
    logic                timeout;
    logic                rd_done;
    logic [DATA_W-1:0]   rd_data;

    // Round-robin pick: on contention the requester that did not win last time goes next.
    always_comb begin
        sel_valid = i_request_0 | i_request_1;
        if (i_request_0 && i_request_1) begin
            sel_id = ~last_grant;
        end else begin
            sel_id = i_request_1 ? REQ_SAVE : REQ_CPU;
        end
        sel_write   = (sel_id == REQ_SAVE) ? i_write_1   : i_write_0;
        sel_address = (sel_id == REQ_SAVE) ? i_address_1 : i_address_0;
        sel_data    = (sel_id == REQ_SAVE) ? i_data_1    : i_data_0;
    end

    // The write-ack cycle is spent in S_IDLE; blocking issue there keeps a still-held request from re-issuing.
    assign issue = (state == S_IDLE) && sel_valid && !i_busy && !wr_ack;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    state_nxt = sel_write ? S_WRITE_ACK : S_READ_WAIT;
                end
            end
            S_WRITE_ACK: state_nxt = S_IDLE;
            S_READ_WAIT: begin
                if (i_ack || timeout) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Read completion is combinational from the SI ack; write completion comes from the registered wr_ack.
    always_comb begin
        rd_done = 1'b0;
        rd_data = '0;
        if ((state == S_READ_WAIT) && (i_ack || timeout)) begin
            rd_done = 1'b1;
            rd_data = i_ack ? i_data : DATA_W'(TIMEOUT_FILL);
        end
        o_ack_0  = (wr_ack || rd_done) && (last_grant == REQ_CPU);
        o_ack_1  = (wr_ack || rd_done) && (last_grant == REQ_SAVE);
        o_data_0 = (rd_done && (last_grant == REQ_CPU))  ? rd_data : '0;
        o_data_1 = (rd_done && (last_grant == REQ_SAVE)) ? rd_data : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_request  <= 1'b0;
            o_write    <= 1'b0;
            o_address  <= '0;
            o_data     <= '0;
            last_grant <= REQ_SAVE;
            wr_ack     <= 1'b0;
        end else begin
            o_request <= issue;
            o_write   <= issue & sel_write;
            o_address <= issue ? sel_address : '0;
            o_data    <= issue ? sel_data : '0;
            if (issue) begin
                last_grant <= sel_id;
            end
            wr_ack <= (state == S_WRITE_ACK);
        end
    end

`ifdef N64_EEPROM_ARB_TIMEOUT_EN
    localparam int unsigned TIMER_W = 4;

    logic [TIMER_W-1:0] wait_cnt;

    // Watchdog: an ack that coincides with the limit still wins.
    assign timeout = (state == S_READ_WAIT) && !i_ack && (wait_cnt == TIMER_W'(TIMEOUT_CYCLES));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt <= '0;
            o_error  <= 1'b0;
        end else begin
            if (issue && !sel_write) begin
                wait_cnt <= '0;
            end else if (state == S_READ_WAIT) begin
                wait_cnt <= wait_cnt + TIMER_W'(1);
            end
            if (timeout) begin
                o_error <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign o_error = 1'b0;
`endif

endmodule
